// File: rtl/keypad_scan_ctrl.sv
// keypad_scan_ctrl: 4x4 key-matrix scanner with per-scan debounce and a
// 4-entry first-word-fall-through event FIFO drained by a valid/pop handshake.
// Rows are driven one-cold.
// Columns are sampled active-low once per row dwell.
// A change is committed only after DEBOUNCE_SCANS identical full scans.
module keypad_scan_ctrl #(
   parameter int CLK_DIV        = 2500,
   parameter int SETTLE         = 16,
   parameter int DEBOUNCE_SCANS = 4
) (
   input  logic        clk,
   input  logic        RST,
   input  logic        enable,
   input  logic [3:0]  col,
   output logic [3:0]  row,
   output logic [15:0] key_state,
   output logic        evt_valid,
   output logic [4:0]  evt_data,
   input  logic        evt_pop,
   output logic [2:0]  evt_count,
   output logic        overflow,
   input  logic        ovf_clr,
   output logic        irq
);

   localparam int         DW      = $clog2(CLK_DIV);
   localparam logic [3:0] DEB     = 4'(DEBOUNCE_SCANS);
   localparam logic [DW-1:0] SAMPLE_AT = DW'(SETTLE);
   localparam logic [DW-1:0] DWELL_END = DW'(CLK_DIV - 1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SCAN   = 2'd1,
      ST_UPDATE = 2'd2,
      ST_EMIT   = 2'd3
   } state_t;

   // One-cold row drive for a given state/row index; all rows idle outside SCAN.
   function automatic logic [3:0] row_drive(input state_t st, input logic [1:0] idx);
      logic [3:0] r;
      if (st == ST_SCAN) begin
         r = ~(4'b0001 << idx);
      end else begin
         r = 4'b1111;
      end
      return r;
   endfunction

   // Sequencer state
   state_t        state_r, state_nxt_s;
   logic [1:0]    row_idx_r, row_idx_nxt_s;
   logic [DW-1:0] dwell_r, dwell_nxt_s;
   logic [3:0]    emit_k_r, emit_k_nxt_s;
   logic [15:0]   scan_buf_r, scan_buf_nxt_s;
   logic [15:0]   last_scan_r, last_scan_nxt_s;
   logic [3:0]    stable_cnt_r, stable_cnt_nxt_s;
   logic [15:0]   key_state_r, key_state_nxt_s;
   logic [15:0]   diff_r, diff_nxt_s;
   logic [3:0]    row_r;

   // Event FIFO state
   logic [4:0]    mem_r [4];
   logic [4:0]    mem_nxt_s [4];
   logic [1:0]    rd_ptr_r, rd_ptr_nxt_s;
   logic [1:0]    wr_ptr_r, wr_ptr_nxt_s;
   logic [2:0]    count_r, count_nxt_s;
   logic          overflow_r, overflow_nxt_s;
   logic          evt_valid_r, evt_data_valid_unused_s;
   logic [4:0]    evt_data_r;
   logic          irq_r;

   logic          push_s;
   logic [4:0]    push_data_s;
   logic          pop_ok_s;
   logic          full_s;
   logic          push_acc_s;
   logic          drop_s;

   assign evt_data_valid_unused_s = 1'b0;

   // Scan sequencer next-state: row stepping, column capture, debounce and emit walk.
   always_comb begin
      state_nxt_s      = state_r;
      row_idx_nxt_s    = row_idx_r;
      dwell_nxt_s      = dwell_r;
      emit_k_nxt_s     = emit_k_r;
      scan_buf_nxt_s   = scan_buf_r;
      last_scan_nxt_s  = last_scan_r;
      stable_cnt_nxt_s = stable_cnt_r;
      key_state_nxt_s  = key_state_r;
      diff_nxt_s       = diff_r;
      push_s           = 1'b0;
      push_data_s      = 5'd0;
      case (state_r)
         ST_IDLE: begin
            if (enable) begin
               state_nxt_s   = ST_SCAN;
               row_idx_nxt_s = 2'd0;
               dwell_nxt_s   = {DW{1'b0}};
            end else begin
               state_nxt_s   = ST_IDLE;
            end
         end
         ST_SCAN: begin
            if (!enable) begin
               state_nxt_s      = ST_IDLE;
               scan_buf_nxt_s   = 16'h0000;
               stable_cnt_nxt_s = 4'd0;
               row_idx_nxt_s    = 2'd0;
               dwell_nxt_s      = {DW{1'b0}};
            end else begin
               if (dwell_r == SAMPLE_AT) begin
                  scan_buf_nxt_s[{row_idx_r, 2'b00} +: 4] = ~col;
               end else begin
                  scan_buf_nxt_s = scan_buf_r;
               end
               if (dwell_r == DWELL_END) begin
                  dwell_nxt_s = {DW{1'b0}};
                  if (row_idx_r == 2'd3) begin
                     state_nxt_s = ST_UPDATE;
                  end else begin
                     row_idx_nxt_s = row_idx_r + 2'd1;
                  end
               end else begin
                  dwell_nxt_s = dwell_r + {{(DW-1){1'b0}}, 1'b1};
               end
            end
         end
         ST_UPDATE: begin
            if (!enable) begin
               state_nxt_s      = ST_IDLE;
               scan_buf_nxt_s   = 16'h0000;
               stable_cnt_nxt_s = 4'd0;
            end else begin
               if (scan_buf_r == last_scan_r) begin
                  if (stable_cnt_r >= DEB) begin
                     stable_cnt_nxt_s = DEB;
                  end else begin
                     stable_cnt_nxt_s = stable_cnt_r + 4'd1;
                  end
               end else begin
                  last_scan_nxt_s  = scan_buf_r;
                  stable_cnt_nxt_s = 4'd1;
               end
               // Commit only a stable pattern that actually differs from the map.
               if ((stable_cnt_nxt_s == DEB) && (last_scan_nxt_s != key_state_r)) begin
                  diff_nxt_s      = last_scan_nxt_s ^ key_state_r;
                  key_state_nxt_s = last_scan_nxt_s;
                  emit_k_nxt_s    = 4'd0;
                  state_nxt_s     = ST_EMIT;
               end else begin
                  state_nxt_s   = ST_SCAN;
                  row_idx_nxt_s = 2'd0;
                  dwell_nxt_s   = {DW{1'b0}};
               end
            end
         end
         ST_EMIT: begin
            // Walk every key code in ascending order so events come out sorted.
            push_s      = diff_r[emit_k_r];
            push_data_s = {key_state_r[emit_k_r], emit_k_r};
            if (emit_k_r == 4'd15) begin
               emit_k_nxt_s = 4'd0;
               if (enable) begin
                  state_nxt_s   = ST_SCAN;
                  row_idx_nxt_s = 2'd0;
                  dwell_nxt_s   = {DW{1'b0}};
               end else begin
                  state_nxt_s      = ST_IDLE;
                  scan_buf_nxt_s   = 16'h0000;
                  stable_cnt_nxt_s = 4'd0;
               end
            end else begin
               emit_k_nxt_s = emit_k_r + 4'd1;
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // FIFO next-state: simultaneous push/pop on a full FIFO is accepted without loss.
   always_comb begin
      mem_nxt_s    = mem_r;
      rd_ptr_nxt_s = rd_ptr_r;
      wr_ptr_nxt_s = wr_ptr_r;
      count_nxt_s  = count_r;
      pop_ok_s     = evt_pop && (count_r != 3'd0);
      full_s       = (count_r == 3'd4);
      push_acc_s   = push_s && (!full_s || pop_ok_s);
      drop_s       = push_s && full_s && !pop_ok_s;
      if (push_acc_s) begin
         mem_nxt_s[wr_ptr_r] = push_data_s;
         wr_ptr_nxt_s        = wr_ptr_r + 2'd1;
      end else begin
         wr_ptr_nxt_s        = wr_ptr_r;
      end
      if (pop_ok_s) begin
         rd_ptr_nxt_s = rd_ptr_r + 2'd1;
      end else begin
         rd_ptr_nxt_s = rd_ptr_r;
      end
      case ({push_acc_s, pop_ok_s})
         2'b10:   count_nxt_s = count_r + 3'd1;
         2'b01:   count_nxt_s = count_r - 3'd1;
         default: count_nxt_s = count_r;
      endcase
      // A drop in the same cycle as a clear leaves the flag set.
      if (drop_s) begin
         overflow_nxt_s = 1'b1;
      end else if (ovf_clr) begin
         overflow_nxt_s = 1'b0;
      end else begin
         overflow_nxt_s = overflow_r;
      end
   end

   // State and output registers; every output is a flop fed from next-state values.
   always_ff @(posedge clk) begin
      if (RST) begin
         state_r      <= ST_IDLE;
         row_idx_r    <= 2'd0;
         dwell_r      <= {DW{1'b0}};
         emit_k_r     <= 4'd0;
         scan_buf_r   <= 16'h0000;
         last_scan_r  <= 16'h0000;
         stable_cnt_r <= 4'd0;
         key_state_r  <= 16'h0000;
         diff_r       <= 16'h0000;
         row_r        <= 4'b1111;
         mem_r        <= '{default: 5'd0};
         rd_ptr_r     <= 2'd0;
         wr_ptr_r     <= 2'd0;
         count_r      <= 3'd0;
         overflow_r   <= 1'b0;
         evt_valid_r  <= 1'b0;
         evt_data_r   <= 5'd0;
         irq_r        <= 1'b0;
      end else begin
         state_r      <= state_nxt_s;
         row_idx_r    <= row_idx_nxt_s;
         dwell_r      <= dwell_nxt_s;
         emit_k_r     <= emit_k_nxt_s;
         scan_buf_r   <= scan_buf_nxt_s;
         last_scan_r  <= last_scan_nxt_s;
         stable_cnt_r <= stable_cnt_nxt_s;
         key_state_r  <= key_state_nxt_s;
         diff_r       <= diff_nxt_s;
         row_r        <= row_drive(state_nxt_s, row_idx_nxt_s);
         mem_r        <= mem_nxt_s;
         rd_ptr_r     <= rd_ptr_nxt_s;
         wr_ptr_r     <= wr_ptr_nxt_s;
         count_r      <= count_nxt_s;
         overflow_r   <= overflow_nxt_s;
         evt_valid_r  <= (count_nxt_s != 3'd0) | evt_data_valid_unused_s;
         evt_data_r   <= mem_nxt_s[rd_ptr_nxt_s];
         irq_r        <= (count_nxt_s != 3'd0) | overflow_nxt_s;
      end
   end

   assign row       = row_r;
   assign key_state = key_state_r;
   assign evt_valid = evt_valid_r;
   assign evt_data  = evt_data_r;
   assign evt_count = count_r;
   assign overflow  = overflow_r;
   assign irq       = irq_r;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Directed bench for keypad_scan_ctrl with a small key-matrix model.
module tb_keypad_scan_ctrl;

   logic        clk = 1'b0;
   logic        RST = 1'b1;
   logic        enable = 1'b0;
   logic        evt_pop = 1'b0;
   logic        ovf_clr = 1'b0;
   logic [3:0]  col;
   logic [3:0]  row;
   logic [15:0] key_state;
   logic        evt_valid;
   logic [4:0]  evt_data;
   logic [2:0]  evt_count;
   logic        overflow;
   logic        irq;
   logic [15:0] keys = 16'h0000;
   int          n_chk = 0;
   int          n_fail = 0;

   keypad_scan_ctrl #(.CLK_DIV(8), .SETTLE(2), .DEBOUNCE_SCANS(3)) dut (
      .clk(clk), .RST(RST), .enable(enable), .col(col), .row(row),
      .key_state(key_state), .evt_valid(evt_valid), .evt_data(evt_data),
      .evt_pop(evt_pop), .evt_count(evt_count), .overflow(overflow),
      .ovf_clr(ovf_clr), .irq(irq)
   );

   always #5 clk = ~clk;

   // Matrix model: a pressed key pulls its column low while its row is driven.
   always_comb begin
      col = 4'hF;
      case (row)
         4'b1110: col = ~keys[3:0];
         4'b1101: col = ~keys[7:4];
         4'b1011: col = ~keys[11:8];
         4'b0111: col = ~keys[15:12];
         default: col = 4'hF;
      endcase
   end

   // Hard stop in case a step never returns.
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pop();
      evt_pop = 1'b1;
      @(negedge clk);
      evt_pop = 1'b0;
   endtask

   task automatic wait_row(input logic [3:0] r, input string tag);
      int t = 0;
      while (row !== r && t < 200) begin
         @(negedge clk);
         t++;
      end
      chk(tag, row, r);
   endtask

   // Returns in the first cycle of the next full scan.
   task automatic wait_update();
      int t = 0;
      wait_row(4'b1111, "wait_update_end");
      while (row === 4'b1111 && t < 40) begin
         @(negedge clk);
         t++;
      end
      chk("wait_scan_start", row, 4'b1110);
   endtask

   initial begin
      logic [3:0] exp_row;
      logic [4:0] exp_q [4];

      // Reset values
      cyc(2);
      chk("rst_row", row, 4'b1111);
      chk("rst_key_state", key_state, 16'h0000);
      chk("rst_evt_valid", evt_valid, 1'b0);
      chk("rst_evt_data", evt_data, 5'h00);
      chk("rst_evt_count", evt_count, 3'd0);
      chk("rst_overflow", overflow, 1'b0);
      chk("rst_irq", irq, 1'b0);

      // Scan sequence: 8 cycles per row, one idle-row cycle, 33-cycle period
      RST = 1'b0;
      enable = 1'b1;
      @(posedge clk);
      for (int c = 0; c < 34; c++) begin
         @(negedge clk);
         if (c < 32)       exp_row = ~(4'b0001 << (c / 8));
         else if (c == 32) exp_row = 4'b1111;
         else              exp_row = 4'b1110;
         chk($sformatf("scan_row_c%0d", c), row, exp_row);
      end
      chk("scan_no_events", evt_count, 3'd0);

      // Single press of key 5 (row 1, col 1) and its release
      keys = 16'h0020;
      cyc(200);
      chk("press5_key_state", key_state, 16'h0020);
      chk("press5_count", evt_count, 3'd1);
      chk("press5_valid", evt_valid, 1'b1);
      chk("press5_data", evt_data, 5'h15);
      chk("press5_irq", irq, 1'b1);
      pop();
      chk("press5_pop_count", evt_count, 3'd0);
      chk("press5_pop_irq", irq, 1'b0);
      keys = 16'h0000;
      cyc(200);
      chk("rel5_data", evt_data, 5'h05);
      chk("rel5_count", evt_count, 3'd1);
      chk("rel5_key_state", key_state, 16'h0000);
      pop();
      chk("rel5_pop_count", evt_count, 3'd0);

      // Bounce: key 5 toggles on alternate scans
      wait_update();
      for (int i = 0; i < 10; i++) begin
         keys = (i % 2 == 1) ? 16'h0020 : 16'h0000;
         wait_update();
      end
      keys = 16'h0000;
      chk("bounce_key_state", key_state, 16'h0000);
      chk("bounce_count", evt_count, 3'd0);

      // Simultaneous keys 0 and 15
      keys = 16'h8001;
      cyc(200);
      chk("simul_count", evt_count, 3'd2);
      chk("simul_head0", evt_data, 5'h10);
      chk("simul_key_state", key_state, 16'h8001);
      pop();
      chk("simul_head1", evt_data, 5'h1F);
      chk("simul_count1", evt_count, 3'd1);
      pop();
      keys = 16'h0000;
      cyc(200);
      chk("simul_rel_count", evt_count, 3'd2);
      chk("simul_rel_head0", evt_data, 5'h00);
      pop();
      chk("simul_rel_head1", evt_data, 5'h0F);
      pop();
      chk("simul_rel_empty", evt_count, 3'd0);

      // Overflow: six presses, FIFO keeps the first four
      keys = 16'h003F;
      cyc(200);
      chk("ovf_count", evt_count, 3'd4);
      chk("ovf_flag", overflow, 1'b1);
      chk("ovf_irq", irq, 1'b1);
      chk("ovf_head", evt_data, 5'h10);
      ovf_clr = 1'b1;
      cyc(1);
      ovf_clr = 1'b0;
      chk("ovf_clr_flag", overflow, 1'b0);
      chk("ovf_clr_count", evt_count, 3'd4);

      // Full FIFO: pop in the same cycle as the release-5 push (EMIT cycle 5)
      wait_update();
      keys = 16'h001F;
      wait_update();
      wait_update();
      wait_row(4'b1111, "full_update");
      cyc(6);
      evt_pop = 1'b1;
      cyc(1);
      evt_pop = 1'b0;
      chk("full_pushpop_count", evt_count, 3'd4);
      chk("full_pushpop_ovf", overflow, 1'b0);
      exp_q = '{5'h11, 5'h12, 5'h13, 5'h05};
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("drain_%0d", i), evt_data, exp_q[i]);
         pop();
      end
      chk("drain_empty", evt_count, 3'd0);
      chk("drain_key_state", key_state, 16'h001F);

      // Enable dropped during row 1011
      wait_row(4'b1011, "row1011");
      enable = 1'b0;
      cyc(1);
      chk("endrop_row", row, 4'b1111);
      chk("endrop_key_state", key_state, 16'h001F);
      chk("endrop_count", evt_count, 3'd0);
      cyc(3);
      chk("endrop_idle_row", row, 4'b1111);

      // Enable dropped in EMIT cycle 0; key 15 event at cycle 15 still lands
      keys = 16'h801F;
      enable = 1'b1;
      cyc(1);
      chk("restart_row", row, 4'b1110);
      wait_update();
      wait_update();
      wait_row(4'b1111, "emit_update");
      cyc(1);
      enable = 1'b0;
      cyc(14);
      chk("emit_k14_count", evt_count, 3'd0);
      chk("emit_k14_row", row, 4'b1111);
      cyc(1);
      chk("emit_k15_count", evt_count, 3'd0);
      cyc(1);
      chk("emit_done_count", evt_count, 3'd1);
      chk("emit_done_data", evt_data, 5'h1F);
      chk("emit_done_key_state", key_state, 16'h801F);
      cyc(5);
      chk("emit_idle_row", row, 4'b1111);
      chk("emit_idle_count", evt_count, 3'd1);

      // Reset in EMIT
      keys = 16'h001F;
      enable = 1'b1;
      cyc(1);
      wait_update();
      wait_update();
      wait_row(4'b1111, "rst_emit_update");
      cyc(1);
      chk("pre_rst_count", evt_count, 3'd1);
      chk("pre_rst_key_state", key_state, 16'h001F);
      RST = 1'b1;
      cyc(1);
      chk("emit_rst_count", evt_count, 3'd0);
      chk("emit_rst_key_state", key_state, 16'h0000);
      chk("emit_rst_valid", evt_valid, 1'b0);
      chk("emit_rst_data", evt_data, 5'h00);
      chk("emit_rst_row", row, 4'b1111);
      chk("emit_rst_irq", irq, 1'b0);
      RST = 1'b0;
      cyc(5);
      chk("post_rst_count", evt_count, 3'd0);
      chk("post_rst_key_state", key_state, 16'h0000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
